// File: rtl/jtbubl_sndcomm.sv
// Main/sound CPU mailbox: command and reply latches with pending flags,
// plus a gated, fixed-length NMI pulse generator for the sound CPU.
module jtbubl_sndcomm #(
  parameter int   NMI_LEN   = 48,
  parameter logic PEND_INIT = 1'b0
) (
  input  logic       clk24,
  input  logic       rst,
  input  logic       main_latch_we,
  input  logic       main_reply_rd,
  input  logic [7:0] main_dout,
  output logic [7:0] main_din,
  output logic [7:0] main_status,
  input  logic       snd_latch_rd,
  input  logic       snd_reply_we,
  input  logic [7:0] snd_dout,
  input  logic       snd_nmi_en_we,
  input  logic       snd_nmi_dis_we,
  output logic [7:0] snd_latch,
  output logic       snd_nmi_n,
  output logic       cmd_pend,
  output logic       reply_pend
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(NMI_LEN - 1);

  logic [5:0] prev;
  logic [5:0] strb;
  logic [5:0] edg;
  logic       cmd_we_e;
  logic       cmd_rd_e;
  logic       rep_we_e;
  logic       rep_rd_e;
  logic       en_e;
  logic       dis_e;

  logic       nmi_en;
  logic       nmi_req;
  logic       go;
  state_t     state;
  logic [7:0] cnt;

  assign strb = {main_latch_we, snd_latch_rd, snd_reply_we,
                 main_reply_rd, snd_nmi_en_we, snd_nmi_dis_we};
  assign edg  = strb & ~prev;

  assign cmd_we_e = edg[5];
  assign cmd_rd_e = edg[4];
  assign rep_we_e = edg[3];
  assign rep_rd_e = edg[2];
  assign en_e     = edg[1];
  assign dis_e    = edg[0];

  // A new pulse may start from IDLE, or straight out of the gap cycle
  assign go = nmi_req && nmi_en && (state != PULSE);

  assign main_status = {6'b0, reply_pend, cmd_pend};

  // Strobe history, latches, pending flags and NMI enable
  always_ff @(posedge clk24) begin
    if (rst) begin
      prev       <= '0;
      snd_latch  <= '0;
      main_din   <= '0;
      cmd_pend   <= PEND_INIT;
      reply_pend <= PEND_INIT;
      nmi_en     <= 1'b0;
    end else begin
      prev <= strb;
      if (cmd_we_e) begin
        snd_latch <= main_dout;
        cmd_pend  <= 1'b1;
      end else if (cmd_rd_e) begin
        cmd_pend  <= 1'b0;
      end
      if (rep_we_e) begin
        main_din   <= snd_dout;
        reply_pend <= 1'b1;
      end else if (rep_rd_e) begin
        reply_pend <= 1'b0;
      end
      if (dis_e)
        nmi_en <= 1'b0;
      else if (en_e)
        nmi_en <= 1'b1;
    end
  end

  // NMI request queue and pulse sequencer; a fresh write re-arms
  // the request even in the cycle a pulse starts
  always_ff @(posedge clk24) begin
    if (rst) begin
      nmi_req   <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      snd_nmi_n <= 1'b1;
    end else begin
      if (cmd_we_e)
        nmi_req <= 1'b1;
      else if (go)
        nmi_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state     <= PULSE;
            cnt       <= CNT_LOAD;
            snd_nmi_n <= 1'b0;
          end
        end
        PULSE: begin
          if (cnt == 8'd0) begin
            state     <= GAP;
            snd_nmi_n <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (go) begin
            state     <= PULSE;
            cnt       <= CNT_LOAD;
            snd_nmi_n <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          snd_nmi_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Scoreboard bench for jtbubl_sndcomm: event-level reference model,
// directed scenarios followed by randomized strobes.
module tb_jtbubl_sndcomm;

  localparam int LEN = 48;

  logic       clk24 = 1'b0;
  logic       rst;
  logic       main_latch_we;
  logic       main_reply_rd;
  logic [7:0] main_dout;
  logic [7:0] main_din;
  logic [7:0] main_status;
  logic       snd_latch_rd;
  logic       snd_reply_we;
  logic [7:0] snd_dout;
  logic       snd_nmi_en_we;
  logic       snd_nmi_dis_we;
  logic [7:0] snd_latch;
  logic       snd_nmi_n;
  logic       cmd_pend;
  logic       reply_pend;

  jtbubl_sndcomm #(.NMI_LEN(LEN), .PEND_INIT(1'b0)) dut (
    .clk24          (clk24),
    .rst            (rst),
    .main_latch_we  (main_latch_we),
    .main_reply_rd  (main_reply_rd),
    .main_dout      (main_dout),
    .main_din       (main_din),
    .main_status    (main_status),
    .snd_latch_rd   (snd_latch_rd),
    .snd_reply_we   (snd_reply_we),
    .snd_dout       (snd_dout),
    .snd_nmi_en_we  (snd_nmi_en_we),
    .snd_nmi_dis_we (snd_nmi_dis_we),
    .snd_latch      (snd_latch),
    .snd_nmi_n      (snd_nmi_n),
    .cmd_pend       (cmd_pend),
    .reply_pend     (reply_pend)
  );

  always #5 clk24 = ~clk24;

  typedef struct packed {
    logic [7:0] latch;
    logic [7:0] din;
    logic [7:0] status;
    logic       n;
    logic       cp;
    logic       rp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   npulses = 0;

  // reference model state
  int         cyc = 0;
  logic [7:0] m_latch, m_din;
  logic       m_cp, m_rp, m_en, m_req;
  int         m_start;
  logic [5:0] m_prev;

  task automatic model_edge();
    logic [5:0] s, e;
    logic       fire;
    exp_t       x;
    s = {main_latch_we, snd_latch_rd, snd_reply_we,
         main_reply_rd, snd_nmi_en_we, snd_nmi_dis_we};
    if (rst) begin
      m_latch = 0; m_din = 0; m_cp = 0; m_rp = 0;
      m_en = 0; m_req = 0; m_start = -1000; m_prev = 0;
    end else begin
      e = s & ~m_prev;
      m_prev = s;
      // a pulse occupies LEN low cycles plus one high gap cycle
      fire = m_req && m_en && (cyc >= m_start + LEN + 1);
      if (fire) begin
        m_req = 0;
        m_start = cyc;
      end
      if (e[5]) begin
        m_req = 1; m_latch = main_dout; m_cp = 1;
      end else if (e[4]) m_cp = 0;
      if (e[3]) begin
        m_din = snd_dout; m_rp = 1;
      end else if (e[2]) m_rp = 0;
      if (e[0]) m_en = 0;
      else if (e[1]) m_en = 1;
    end
    x.latch  = m_latch;
    x.din    = m_din;
    x.status = {6'b0, m_rp, m_cp};
    x.n      = !(cyc >= m_start && cyc < m_start + LEN);
    x.cp     = m_cp;
    x.rp     = m_rp;
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk24);
      model_edge();
      cyc++;
      #1;
    end
  endtask

  task automatic idle_in();
    main_latch_we = 0; main_reply_rd = 0; snd_latch_rd = 0;
    snd_reply_we = 0; snd_nmi_en_we = 0; snd_nmi_dis_we = 0;
  endtask

  // Monitor: compare every cycle and independently time each pulse
  initial begin
    exp_t e, g;
    int   run;
    run = 0;
    forever begin
      @(negedge clk24);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {snd_latch, main_din, main_status, snd_nmi_n,
             cmd_pend, reply_pend};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got latch=%h din=%h st=%h n=%b cp=%b rp=%b exp latch=%h din=%h st=%h n=%b cp=%b rp=%b",
                   $time, g.latch, g.din, g.status, g.n, g.cp, g.rp,
                   e.latch, e.din, e.status, e.n, e.cp, e.rp);
        end
      end
      if (rst === 1'b1) run = 0;
      else if (snd_nmi_n === 1'b0) run++;
      else if (run > 0) begin
        checks++;
        npulses++;
        if (run != LEN) begin
          errors++;
          $display("FAIL pulse_len got %0d exp %0d", run, LEN);
        end
        run = 0;
      end
    end
  end

  task automatic chk_pulses(input string nm, input int exp_n);
    checks++;
    if (npulses != exp_n) begin
      errors++;
      $display("FAIL %s pulses got %0d exp %0d", nm, npulses, exp_n);
    end
    npulses = 0;
  endtask

  initial begin
    rst = 1; idle_in(); main_dout = 0; snd_dout = 0;
    step(3);
    rst = 0;
    step(2);
    // 1: enable, then long strobe write
    npulses = 0;
    snd_nmi_en_we = 1; step(1); snd_nmi_en_we = 0; step(2);
    main_dout = 8'h5A; main_latch_we = 1; step(4); main_latch_we = 0;
    step(60);
    chk_pulses("t1", 1);
    // 2: disabled write held until enable
    snd_latch_rd = 1; step(1); snd_latch_rd = 0;
    snd_nmi_dis_we = 1; step(1); snd_nmi_dis_we = 0;
    main_dout = 8'h11; main_latch_we = 1; step(2); main_latch_we = 0;
    step(100);
    chk_pulses("t2_off", 0);
    snd_nmi_en_we = 1; step(1); snd_nmi_en_we = 0;
    step(60);
    chk_pulses("t2_on", 1);
    // 3: reply path
    snd_dout = 8'hC3; snd_reply_we = 1; step(2); snd_reply_we = 0;
    step(3);
    main_reply_rd = 1; step(2); main_reply_rd = 0;
    step(3);
    // 4: second write inside a pulse
    main_dout = 8'h01; main_latch_we = 1; step(1); main_latch_we = 0;
    step(9);
    main_dout = 8'h02; main_latch_we = 1; step(1); main_latch_we = 0;
    step(120);
    chk_pulses("t4", 2);
    // 5: simultaneous edges
    snd_latch_rd = 1; step(1); snd_latch_rd = 0; step(1);
    snd_nmi_en_we = 1; snd_nmi_dis_we = 1; step(1); idle_in();
    main_dout = 8'h77; main_latch_we = 1; snd_latch_rd = 1; step(1);
    idle_in(); step(80);
    chk_pulses("t5", 0);
    // 6: reset mid-pulse
    snd_nmi_en_we = 1; step(1); snd_nmi_en_we = 0;
    step(60);
    npulses = 0;
    main_dout = 8'h9E; main_latch_we = 1; step(1); main_latch_we = 0;
    step(21);
    rst = 1; step(1); rst = 0;
    step(80);
    chk_pulses("t6", 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      main_latch_we  = ($urandom_range(0, 9) == 0);
      snd_latch_rd   = ($urandom_range(0, 7) == 0);
      snd_reply_we   = ($urandom_range(0, 7) == 0);
      main_reply_rd  = ($urandom_range(0, 7) == 0);
      snd_nmi_en_we  = ($urandom_range(0, 11) == 0);
      snd_nmi_dis_we = ($urandom_range(0, 29) == 0);
      main_dout      = 8'($urandom);
      snd_dout       = 8'($urandom);
      rst            = ($urandom_range(0, 799) == 0);
      step(1);
    end
    rst = 0; idle_in();
    step(2);
    @(negedge clk24);
    @(negedge clk24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
